// File: rtl/rab_ax_buffer.sv
// rab_ax_buffer: AXI AR/AW stage that turns one slave beat into a RAB lookup and forwards it to master 0/1 or the error path
//
// Ports:
//   s_axi_aclk, s_axi_aresetn        clock, asynchronous active-low reset
//   s_ax_*_i / s_ax_ready_o          slave address beat (addr/id/len/size/user/valid)
//   rab_*_o                          lookup request to the core, held stable from LOOKUP until IDLE
//   rab_accept_i / rab_drop_i        core decision; drop wins when both are high
//   rab_out_addr_i, rab_master_select_i  translated address and target master
//   rab_sent_o                       high in the cycle a master accepts the beat
//   m_ax_*_o, m0/m1_ax_valid_o/_ready_i  shared master fields and per-master handshake
//   drop_*                           request to the error-response generator
//
// Optional build macro RAB_AX_INPUT_SKID_EN: puts a 2-entry FIFO in front of the request
// register so the slave can keep handing over beats while a lookup is outstanding.
module rab_ax_buffer #(
    parameter int unsigned C_AXI_ID_WIDTH   = 8,
    parameter int unsigned C_AXI_USER_WIDTH = 6,
    parameter bit          AX_TYPE          = 1'b0
) (
    input  logic                        s_axi_aclk,
    input  logic                        s_axi_aresetn,
    input  logic [31:0]                 s_ax_addr_i,
    input  logic [C_AXI_ID_WIDTH-1:0]   s_ax_id_i,
    input  logic [7:0]                  s_ax_len_i,
    input  logic [2:0]                  s_ax_size_i,
    input  logic [C_AXI_USER_WIDTH-1:0] s_ax_user_i,
    input  logic                        s_ax_valid_i,
    output logic                        s_ax_ready_o,
    output logic [31:0]                 rab_addr_o,
    output logic [C_AXI_ID_WIDTH-1:0]   rab_id_o,
    output logic [7:0]                  rab_len_o,
    output logic [2:0]                  rab_size_o,
    output logic [C_AXI_USER_WIDTH-1:0] rab_ctrl_o,
    output logic                        rab_type_o,
    output logic                        rab_addr_valid_o,
    input  logic                        rab_accept_i,
    input  logic                        rab_drop_i,
    input  logic [31:0]                 rab_out_addr_i,
    input  logic                        rab_master_select_i,
    output logic                        rab_sent_o,
    output logic [31:0]                 m_ax_addr_o,
    output logic [C_AXI_ID_WIDTH-1:0]   m_ax_id_o,
    output logic [7:0]                  m_ax_len_o,
    output logic [2:0]                  m_ax_size_o,
    output logic [C_AXI_USER_WIDTH-1:0] m_ax_user_o,
    output logic                        m0_ax_valid_o,
    input  logic                        m0_ax_ready_i,
    output logic                        m1_ax_valid_o,
    input  logic                        m1_ax_ready_i,
    output logic [C_AXI_ID_WIDTH-1:0]   drop_id_o,
    output logic [7:0]                  drop_len_o,
    output logic                        drop_valid_o,
    input  logic                        drop_ready_i
);
    typedef enum logic [1:0] {IDLE, LOOKUP, ISSUE, DROP} state_t;
    typedef struct packed {
        logic [31:0]                 addr;
        logic [C_AXI_ID_WIDTH-1:0]   id;
        logic [7:0]                  len;
        logic [2:0]                  size;
        logic [C_AXI_USER_WIDTH-1:0] user;
    } req_t;

    state_t      state_q, state_d;
    req_t        req_q, in_req, slave_req;
    logic [31:0] m_addr_q;
    logic        sel_q, in_valid, m_hs;

    assign slave_req = {s_ax_addr_i, s_ax_id_i, s_ax_len_i, s_ax_size_i, s_ax_user_i};

`ifdef RAB_AX_INPUT_SKID_EN
    req_t       fifo_q [2];
    logic [1:0] cnt_q;
    logic       rd_ptr_q, wr_ptr_q, push, pop;
    assign s_ax_ready_o = cnt_q != 2'd2;
    assign push         = s_ax_valid_i && s_ax_ready_o;
    assign pop          = state_q == IDLE && cnt_q != 2'd0;
    assign in_valid     = pop;
    assign in_req       = fifo_q[rd_ptr_q];
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            cnt_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_q + {1'b0, push} - {1'b0, pop};
            rd_ptr_q <= rd_ptr_q ^ pop;
            wr_ptr_q <= wr_ptr_q ^ push;
        end
    end
    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge s_axi_aclk) begin
        if (push) fifo_q[wr_ptr_q] <= slave_req;
    end
`else
    assign s_ax_ready_o = state_q == IDLE;
    assign in_valid     = s_ax_valid_i;
    assign in_req       = slave_req;
`endif

    assign m0_ax_valid_o = state_q == ISSUE && !sel_q;
    assign m1_ax_valid_o = state_q == ISSUE && sel_q;
    assign m_hs          = (m0_ax_valid_o && m0_ax_ready_i) || (m1_ax_valid_o && m1_ax_ready_i);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? LOOKUP : IDLE;
            LOOKUP:  state_d = rab_drop_i ? DROP : (rab_accept_i ? ISSUE : LOOKUP);
            ISSUE:   state_d = m_hs ? IDLE : ISSUE;
            default: state_d = drop_ready_i ? IDLE : DROP;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q  <= IDLE;
            req_q    <= '0;
            m_addr_q <= '0;
            sel_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) req_q <= in_req;
            // A simultaneous drop overrides accept, so the translation is not latched then.
            if (state_q == LOOKUP && rab_accept_i && !rab_drop_i) begin
                m_addr_q <= rab_out_addr_i;
                sel_q    <= rab_master_select_i;
            end
        end
    end

    assign rab_addr_o       = req_q.addr;
    assign rab_id_o         = req_q.id;
    assign rab_len_o        = req_q.len;
    assign rab_size_o       = req_q.size;
    assign rab_ctrl_o       = req_q.user;
    assign rab_type_o       = AX_TYPE;
    assign rab_addr_valid_o = state_q == LOOKUP;
    // Issue handshake is the send event, so the pulse lines up with it exactly.
    assign rab_sent_o       = m_hs;
    assign m_ax_addr_o      = m_addr_q;
    assign m_ax_id_o        = req_q.id;
    assign m_ax_len_o       = req_q.len;
    assign m_ax_size_o      = req_q.size;
    assign m_ax_user_o      = req_q.user;
    assign drop_valid_o     = state_q == DROP;
    assign drop_id_o        = req_q.id;
    assign drop_len_o       = req_q.len;
endmodule

// File: tb/tb_rab_ax_buffer.sv
// tb_rab_ax_buffer: directed scoreboard bench for rab_ax_buffer
module tb_rab_ax_buffer;
    logic        clk = 1'b0, aresetn = 1'b0;
    logic [31:0] s_addr = '0;
    logic [7:0]  s_id = '0, s_len = '0;
    logic [2:0]  s_size = '0;
    logic [5:0]  s_user = '0;
    logic        s_valid = 1'b0, s_ready;
    logic [31:0] rab_addr;
    logic [7:0]  rab_id, rab_len;
    logic [2:0]  rab_size;
    logic [5:0]  rab_ctrl;
    logic        rab_type, rab_addr_valid;
    logic        accept = 1'b0, drop = 1'b0, msel = 1'b0;
    logic [31:0] out_addr = '0;
    logic        rab_sent;
    logic [31:0] m_addr;
    logic [7:0]  m_id, m_len;
    logic [2:0]  m_size;
    logic [5:0]  m_user;
    logic        m0_valid, m1_valid, m0_ready = 1'b1, m1_ready = 1'b1;
    logic [7:0]  drop_id, drop_len;
    logic        drop_valid, drop_ready = 1'b1;

    always #5 clk = ~clk;

    rab_ax_buffer dut (
        .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
        .s_ax_addr_i(s_addr), .s_ax_id_i(s_id), .s_ax_len_i(s_len), .s_ax_size_i(s_size),
        .s_ax_user_i(s_user), .s_ax_valid_i(s_valid), .s_ax_ready_o(s_ready),
        .rab_addr_o(rab_addr), .rab_id_o(rab_id), .rab_len_o(rab_len), .rab_size_o(rab_size),
        .rab_ctrl_o(rab_ctrl), .rab_type_o(rab_type), .rab_addr_valid_o(rab_addr_valid),
        .rab_accept_i(accept), .rab_drop_i(drop), .rab_out_addr_i(out_addr),
        .rab_master_select_i(msel), .rab_sent_o(rab_sent),
        .m_ax_addr_o(m_addr), .m_ax_id_o(m_id), .m_ax_len_o(m_len), .m_ax_size_o(m_size),
        .m_ax_user_o(m_user), .m0_ax_valid_o(m0_valid), .m0_ax_ready_i(m0_ready),
        .m1_ax_valid_o(m1_valid), .m1_ax_ready_i(m1_ready),
        .drop_id_o(drop_id), .drop_len_o(drop_len), .drop_valid_o(drop_valid),
        .drop_ready_i(drop_ready)
    );

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [7:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [5:0]  user;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   compared = 0, mismatched = 0, sent_cnt = 0, exp_sent = 0, k;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input int kind, input logic [31:0] a, input logic [7:0] id,
                              input logic [7:0] len, input logic [2:0] sz, input logic [5:0] u);
        exp_t x;
        x.kind = kind; x.addr = a; x.id = id; x.len = len; x.size = sz; x.user = u;
        q.push_back(x);
        if (kind != 2) exp_sent++;
    endtask

    // Monitor: kind 0/1 = issue on master 0/1, kind 2 = drop request.
    always @(negedge clk) begin
        if (aresetn) begin
            if ((m0_valid && m0_ready) || (m1_valid && m1_ready)) begin
                k = (m0_valid && m0_ready) ? 0 : 1;
                if (q.size() == 0) chk("unexpected_issue", 64'(k), 64'd99);
                else begin
                    e = q.pop_front();
                    chk("issue_port", 64'(k), 64'(e.kind));
                    chk("issue_addr", 64'(m_addr), 64'(e.addr));
                    chk("issue_id", 64'(m_id), 64'(e.id));
                    chk("issue_len", 64'(m_len), 64'(e.len));
                    chk("issue_size", 64'(m_size), 64'(e.size));
                    chk("issue_user", 64'(m_user), 64'(e.user));
                    chk("sent_at_handshake", 64'(rab_sent), 64'd1);
                end
            end else if (rab_sent) chk("sent_without_handshake", 64'(rab_sent), 64'd0);
            if (drop_valid && drop_ready) begin
                if (q.size() == 0) chk("unexpected_drop", 64'd1, 64'd0);
                else begin
                    e = q.pop_front();
                    chk("drop_kind", 64'd2, 64'(e.kind));
                    chk("drop_id", 64'(drop_id), 64'(e.id));
                    chk("drop_len", 64'(drop_len), 64'(e.len));
                end
            end
            if (m0_valid && m1_valid) chk("both_masters_valid", 64'd1, 64'd0);
            if ((m0_valid || m1_valid) && drop_valid) chk("issue_and_drop", 64'd1, 64'd0);
            if (rab_sent) sent_cnt++;
        end
    end

    task automatic send(input logic [31:0] a, input logic [7:0] id, input logic [7:0] len,
                        input logic [2:0] sz, input logic [5:0] u);
        s_addr = a; s_id = id; s_len = len; s_size = sz; s_user = u; s_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk); #1;
                s_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 64'd0, 64'd1);
        s_valid = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] ea, input logic [7:0] eid, input logic acc,
                          input logic drp, input logic [31:0] oa, input logic sel);
        int n;
        for (n = 0; n < 50 && !rab_addr_valid; n++) @(negedge clk);
        if (!rab_addr_valid) begin
            chk("lookup_timeout", 64'd0, 64'd1);
            return;
        end
        chk("rab_addr", 64'(rab_addr), 64'(ea));
        chk("rab_id", 64'(rab_id), 64'(eid));
        chk("rab_type", 64'(rab_type), 64'd0);
        @(posedge clk); #1;
        accept = acc; drop = drp; out_addr = oa; msel = sel;
        @(posedge clk); #1;
        accept = 1'b0; drop = 1'b0;
        @(negedge clk);
        chk("lookup_deassert", 64'(rab_addr_valid), 64'd0);
        chk("issue_latency", 64'(m0_valid || m1_valid), 64'(acc && !drp));
        chk("drop_latency", 64'(drop_valid), 64'(drp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_s_ready", 64'(s_ready), 64'd1);
        chk("reset_valids", 64'({rab_addr_valid, m0_valid, m1_valid, drop_valid, rab_sent}), 64'd0);
        chk("reset_data", 64'({m_addr, rab_id, drop_len}), 64'd0);
        aresetn = 1'b1;
        @(posedge clk); #1;

        // Single accept to master 0, with the one-cycle capture latency.
        expect_out(0, 32'h8000_0040, 8'h12, 8'd3, 3'd3, 6'h2a);
        send(32'h1000_0040, 8'h12, 8'd3, 3'd3, 6'h2a);
`ifndef RAB_AX_INPUT_SKID_EN
        @(negedge clk);
        chk("capture_latency", 64'(rab_addr_valid), 64'd1);
`endif
        lookup(32'h1000_0040, 8'h12, 1'b1, 1'b0, 32'h8000_0040, 1'b0);

        // Drop path.
        expect_out(2, 32'h0, 8'h05, 8'd7, 3'd0, 6'h0);
        send(32'h2000_0000, 8'h05, 8'd7, 3'd2, 6'h01);
        lookup(32'h2000_0000, 8'h05, 1'b0, 1'b1, 32'h0, 1'b0);

        // Master 1 holds ready low for 10 cycles.
        m1_ready = 1'b0;
        expect_out(1, 32'hdead_beef, 8'h33, 8'd15, 3'd2, 6'h3f);
        send(32'hffff_fffc, 8'h33, 8'd15, 3'd2, 6'h3f);
        lookup(32'hffff_fffc, 8'h33, 1'b1, 1'b0, 32'hdead_beef, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_m1_valid", 64'(m1_valid), 64'd1);
            chk("bp_m0_valid", 64'(m0_valid), 64'd0);
            chk("bp_fields", 64'({m_addr, m_id, m_len}), {16'h0, 32'hdead_beef, 8'h33, 8'd15});
            chk("bp_no_sent", 64'(rab_sent), 64'd0);
`ifndef RAB_AX_INPUT_SKID_EN
            chk("bp_s_ready", 64'(s_ready), 64'd0);
`endif
            @(negedge clk);
        end
        @(posedge clk); #1;
        m1_ready = 1'b1;
        @(posedge clk); #1;

        // Accept and drop together: drop wins.
        expect_out(2, 32'h0, 8'h44, 8'd1, 3'd0, 6'h0);
        send(32'h3000_0100, 8'h44, 8'd1, 3'd1, 6'h02);
        lookup(32'h3000_0100, 8'h44, 1'b1, 1'b1, 32'h9000_0100, 1'b1);

        // Reset while in ISSUE discards the request.
        m0_ready = 1'b0;
        send(32'h4000_0000, 8'h66, 8'd0, 3'd2, 6'h03);
        lookup(32'h4000_0000, 8'h66, 1'b1, 1'b0, 32'hc000_0000, 1'b0);
        @(posedge clk); #1;
        aresetn = 1'b0;
        @(negedge clk);
        chk("rst_issue_valids", 64'({rab_addr_valid, m0_valid, m1_valid, drop_valid, rab_sent}), 64'd0);
        chk("rst_issue_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        aresetn = 1'b1;
        m0_ready = 1'b1;
        expect_out(0, 32'h0abc_0000, 8'h77, 8'd2, 3'd1, 6'h05);
        send(32'h5000_0000, 8'h77, 8'd2, 3'd1, 6'h05);
        lookup(32'h5000_0000, 8'h77, 1'b1, 1'b0, 32'h0abc_0000, 1'b0);

`ifdef RAB_AX_INPUT_SKID_EN
        // Three back-to-back beats while the core is stalled.
        @(posedge clk); #1;
        expect_out(0, 32'h0000_1000, 8'ha1, 8'd0, 3'd2, 6'h0);
        expect_out(0, 32'h0000_2000, 8'ha2, 8'd1, 3'd2, 6'h0);
        expect_out(0, 32'h0000_3000, 8'ha3, 8'd2, 3'd2, 6'h0);
        send(32'h6000_1000, 8'ha1, 8'd0, 3'd2, 6'h0);
        send(32'h6000_2000, 8'ha2, 8'd1, 3'd2, 6'h0);
        send(32'h6000_3000, 8'ha3, 8'd2, 3'd2, 6'h0);
        @(negedge clk);
        chk("skid_full_s_ready", 64'(s_ready), 64'd0);
        lookup(32'h6000_1000, 8'ha1, 1'b1, 1'b0, 32'h0000_1000, 1'b0);
        lookup(32'h6000_2000, 8'ha2, 1'b1, 1'b0, 32'h0000_2000, 1'b0);
        lookup(32'h6000_3000, 8'ha3, 1'b1, 1'b0, 32'h0000_3000, 1'b0);
`endif

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("sent_count", 64'(sent_cnt), 64'(exp_sent));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
